// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the 64-bit data-memory interface.
// Takes one request at a time, forms the effective address, performs the
// memory access (read-modify-write for sub-doubleword stores) and returns
// a sized, extended load result or an error flag.
module load_store_unit #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_INDEX_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] load_result,
    output logic                  error,
    output logic                  memwrite,
    output logic                  memread,
    output logic [DATA_WIDTH-1:0] add,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            lane_q, lane_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
    logic                  is_load_q, is_load_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0] add_q, add_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    // Effective address of the presented request; only the low index and
    // lane bits matter, the rest alias.
    logic [DATA_WIDTH-1:0] req_ea;
    logic                  ea_hi_unused;
    logic                  req_misaligned;
    logic                  req_err;

    assign req_ea       = base + offset;
    assign ea_hi_unused = ^req_ea[DATA_WIDTH-1:MEM_INDEX_BITS+3];

    // Legality and alignment of the presented request.
    always_comb begin
        req_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   req_misaligned = req_ea[0];
            2'b10:   req_misaligned = |req_ea[1:0];
            2'b11:   req_misaligned = |req_ea[2:0];
            default: req_misaligned = 1'b0;
        endcase
        req_err = (is_load && is_store)
               || (!is_load && !is_store)
               || (is_load && (funct3 == 3'b111))
               || (is_store && funct3[2])
               || req_misaligned;
    end

    // Store lane merge: replace the addressed bytes of the old doubleword
    // with the low bytes of store_data shifted into place.
    logic [DATA_WIDTH-1:0] store_shift;
    logic [DATA_WIDTH-1:0] merged_data;
    logic [7:0]            lane_mask;

    assign store_shift = store_data_q << {lane_q, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [2:0] LANE_IDX = 3'(gi);
            assign lane_mask[gi] =
                (funct3_q[1:0] == 2'b00) ? (lane_q == LANE_IDX) :
                (funct3_q[1:0] == 2'b01) ? (lane_q[2:1] == LANE_IDX[2:1]) :
                (funct3_q[1:0] == 2'b10) ? (lane_q[2] == LANE_IDX[2]) :
                1'b1;
            assign merged_data[gi*8 +: 8] = lane_mask[gi] ? store_shift[gi*8 +: 8]
                                                          : read_data[gi*8 +: 8];
        end
    endgenerate

    // Load extraction from the captured doubleword.
    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        load_shift = buf_q >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){load_shift[7]}},   load_shift[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){load_shift[15]}}, load_shift[15:0]};
            3'b010:  load_ext = {{(DATA_WIDTH-32){load_shift[31]}}, load_shift[31:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},  load_shift[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, load_shift[15:0]};
            3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, load_shift[31:0]};
            default: load_ext = load_shift;
        endcase
    end

    // Next-state logic and request latching.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        funct3_d     = funct3_q;
        store_data_d = store_data_q;
        is_load_d    = is_load_q;
        err_d        = err_q;
        buf_d        = buf_q;
        add_d        = add_q;
        write_data_d = write_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lane_d       = req_ea[2:0];
                    funct3_d     = funct3;
                    store_data_d = store_data;
                    is_load_d    = is_load;
                    err_d        = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else begin
                        add_d = {{(DATA_WIDTH-MEM_INDEX_BITS){1'b0}},
                                 req_ea[MEM_INDEX_BITS+2:3]};
                        if (is_load) begin
                            state_d = S_READ;
                        end else if (funct3[1:0] == 2'b11) begin
                            write_data_d = store_data;
                            state_d      = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                buf_d = read_data;
                if (is_load_q) begin
                    state_d = S_RESP;
                end else begin
                    write_data_d = merged_data;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            funct3_q     <= '0;
            store_data_q <= '0;
            is_load_q    <= 1'b0;
            err_q        <= 1'b0;
            buf_q        <= '0;
            add_q        <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            funct3_q     <= funct3_d;
            store_data_q <= store_data_d;
            is_load_q    <= is_load_d;
            err_q        <= err_d;
            buf_q        <= buf_d;
            add_q        <= add_d;
            write_data_q <= write_data_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign memread     = (state_q == S_READ);
    assign memwrite    = (state_q == S_WRITE);
    assign resp_valid  = (state_q == S_RESP);
    assign error       = err_q;
    assign load_result = (is_load_q && !err_q) ? load_ext : '0;
    assign add         = add_q;
    assign write_data  = write_data_q;

endmodule
